// File: rtl/audio_pkg.sv
// Shared types and constants for the audio serial link blocks.
package audio_pkg;

  localparam int AUDIO_WORD_W = 32;
  localparam int AUDIO_HALF_W = 16;

  // Deserializer lock state: searching for a frame start, or tracking frames.
  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } s2p_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage input synchronizer with registered level and edge pulses.
// The level and the edge pulses come out of the same register stage, so
// several instances fed from related lines stay cycle-aligned.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   level_reg;
  logic                   rise_reg;
  logic                   fall_reg;

  // Metastability chain: din enters at bit 0 and walks towards the top bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
    end
  end

  // Keep the previous synchronized value and derive one-cycle edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      level_reg <= sync_reg[SYNC_STAGES-1];
      rise_reg  <= sync_reg[SYNC_STAGES-1] & ~level_reg;
      fall_reg  <= ~sync_reg[SYNC_STAGES-1] & level_reg;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/serial_to_parallel.sv
// Receive deserializer for the audio serial link. Oversamples the bit clock,
// frame sync and data lines in the system clock domain, aligns to frame
// starts (ws falling, one-bit delayed data) and emits complete words.
module serial_to_parallel
  import audio_pkg::*;
#(
  parameter int WIDTH       = AUDIO_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_in,
  input  logic             ws_in,
  input  logic             sdata_in,
  output logic [WIDTH-1:0] parallel,
  output logic             valid,
  output logic             frame_err,
  output logic             locked
);

  localparam int               CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
  localparam int               NUM_LINES  = 3;
  localparam int               LINE_SCLK  = 0;
  localparam int               LINE_WS    = 1;
  localparam int               LINE_SDATA = 2;

  // ---------------------------------------------------------------------
  // Input conditioning: one synchronizer per serial line.
  // ---------------------------------------------------------------------
  logic [NUM_LINES-1:0] line_raw;
  logic [NUM_LINES-1:0] line_level;
  logic [NUM_LINES-1:0] line_rise;
  logic [NUM_LINES-1:0] line_fall;

  assign line_raw = {sdata_in, ws_in, sclk_in};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_sync
      sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (line_raw[gi]),
        .level(line_level[gi]),
        .rise (line_rise[gi]),
        .fall (line_fall[gi])
      );
    end
  endgenerate

  // Only the bit-clock edge and the ws/sdata levels drive the datapath.
  logic unused_edges;
  assign unused_edges = &{1'b0, line_level[LINE_SCLK],
                          line_rise[LINE_SDATA:LINE_WS], line_fall};

  logic sample;
  logic ws_s;
  logic sdata_s;

  assign sample  = line_rise[LINE_SCLK];
  assign ws_s    = line_level[LINE_WS];
  assign sdata_s = line_level[LINE_SDATA];

  // ---------------------------------------------------------------------
  // State and datapath registers.
  // ---------------------------------------------------------------------
  s2p_state_t         state_reg,     state_next;
  logic [CNT_W-1:0]   bit_cnt_reg,   bit_cnt_next;
  logic [WIDTH-2:0]   shreg_reg,     shreg_next;
  logic [WIDTH-1:0]   parallel_reg,  parallel_next;
  logic               valid_reg,     valid_next;
  logic               frame_err_reg, frame_err_next;
  logic               ws_prev_reg,   ws_prev_next;
  logic               locked_reg;
  logic               frame_start;

  // ws value at the previous sample event, not the previous clk cycle.
  assign frame_start = sample & ~ws_s & ws_prev_reg;

  // Next-state, datapath and strobe decisions; everything advances on samples.
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shreg_next     = shreg_reg;
    parallel_next  = parallel_reg;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
    ws_prev_next   = ws_prev_reg;

    if (sample) begin
      ws_prev_next = ws_s;
      shreg_next   = {shreg_reg[WIDTH-3:0], sdata_s};
      bit_cnt_next = frame_start ? '0 : bit_cnt_reg + 1'b1;

      unique case (state_reg)
        HUNT: begin
          if (frame_start) begin
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (frame_start) begin
            if (bit_cnt_reg == LAST_BIT) begin
              // The frame-start sample carries the LSB of the finished word.
              parallel_next = {shreg_reg, sdata_s};
              valid_next    = 1'b1;
            end else begin
              // Short frame: drop the word but stay aligned to this new start.
              frame_err_next = 1'b1;
            end
          end else if (bit_cnt_reg == LAST_BIT) begin
            // Overlong frame: framing is lost, search again.
            frame_err_next = 1'b1;
            state_next     = HUNT;
          end
        end
        default: begin
          state_next = HUNT;
        end
      endcase
    end
  end

  // Register all state and outputs; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HUNT;
      bit_cnt_reg   <= '0;
      shreg_reg     <= '0;
      parallel_reg  <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      ws_prev_reg   <= 1'b0;
      locked_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shreg_reg     <= shreg_next;
      parallel_reg  <= parallel_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      ws_prev_reg   <= ws_prev_next;
      locked_reg    <= (state_next == SHIFT);
    end
  end

  assign parallel  = parallel_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign locked    = locked_reg;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel: a frame-level reference model
// queues expected words/errors as serial samples are driven, and a monitor
// compares every valid/frame_err pulse against the queue.
module tb_serial_to_parallel;
  import audio_pkg::*;

  localparam int W     = AUDIO_WORD_W;
  localparam int SS    = 2;
  localparam int CLK_P = 10;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         sclk_in  = 1'b0;
  logic         ws_in    = 1'b1;
  logic         sdata_in = 1'b0;
  logic [W-1:0] parallel;
  logic         valid;
  logic         frame_err;
  logic         locked;

  serial_to_parallel #(
    .WIDTH      (W),
    .SYNC_STAGES(SS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk_in  (sclk_in),
    .ws_in    (ws_in),
    .sdata_in (sdata_in),
    .parallel (parallel),
    .valid    (valid),
    .frame_err(frame_err),
    .locked   (locked)
  );

  always #(CLK_P/2) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_err;
    logic [W-1:0] data;
    int           rise_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vcyc_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_valid  = 0;
  int   n_err    = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // ---------------- reference model (frame level) ----------------
  bit           m_locked    = 1'b0;
  bit           m_prev_ws   = 1'b0;
  bit           m_q[$];
  logic [W-1:0] m_last_word = '0;

  function automatic void model_step(bit ws, bit d);
    bit           fs;
    logic [W-1:0] word;
    exp_t         e;
    fs = !ws && m_prev_ws;
    m_prev_ws = ws;
    e.rise_cyc = cyc;
    if (fs) begin
      if (m_locked) begin
        if (m_q.size() == W-1) begin
          word = '0;
          foreach (m_q[i]) word = {word[W-2:0], m_q[i]};
          word = {word[W-2:0], d};
          m_last_word = word;
          e.is_err = 1'b0;
        end else begin
          e.is_err = 1'b1;
        end
        e.data = m_last_word;
        exp_q.push_back(e);
      end
      m_locked = 1'b1;
      m_q.delete();
    end else if (m_locked) begin
      if (m_q.size() == W-1) begin
        e.is_err = 1'b1;
        e.data   = m_last_word;
        exp_q.push_back(e);
        m_locked = 1'b0;
        m_q.delete();
      end else begin
        m_q.push_back(d);
      end
    end
  endfunction

  function automatic void model_reset();
    m_locked    = 1'b0;
    m_prev_ws   = 1'b0;
    m_last_word = '0;
    m_q.delete();
  endfunction

  // ---------------- monitor ----------------
  exp_t mon_e;
  int   mon_lat;
  always @(negedge clk) begin
    if (!rst && (valid || frame_err)) begin
      check("valid_err_exclusive", 64'(valid & frame_err), 64'd0);
      if (valid) begin
        n_valid++;
        vcyc_q.push_back(cyc);
      end
      if (frame_err) n_err++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got valid=%0b frame_err=%0b parallel=0x%0h expected no output",
                 valid, frame_err, parallel);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind_is_err", 64'(frame_err), 64'(mon_e.is_err));
        check("parallel", 64'(parallel), 64'(mon_e.data));
        mon_lat = cyc - (mon_e.rise_cyc + 1);
        n_checks++;
        if (mon_lat >= SS && mon_lat <= SS + 2) n_pass++;
        else $display("FAIL latency: got %0d clk expected %0d..%0d", mon_lat, SS, SS + 2);
      end
      $display("out valid=%0b err=%0b parallel=0x%08h cyc=%0d", valid, frame_err, parallel, cyc);
    end
  end

  // ---------------- stimulus ----------------
  int half = 30;
  bit last_lsb = 1'b0;

  task automatic send_bit(input bit ws, input bit d);
    sclk_in  = 1'b0;
    ws_in    = ws;
    sdata_in = d;
    #(half);
    model_step(ws, d);
    sclk_in = 1'b1;
    #(half);
  endtask

  // One frame: first sample carries the previous word's LSB, then MSB..bit1.
  task automatic send_frame(input logic [W-1:0] word, input int len, input int ws_low);
    bit d;
    for (int i = 0; i < len; i++) begin
      if (i == 0) d = last_lsb;
      else if (i < W) d = word[W-i];
      else d = 1'($urandom);
      send_bit(i >= ws_low, d);
    end
    last_lsb = word[0];
    $display("frame word=0x%08h len=%0d", word, len);
  endtask

  task automatic align();
    @(posedge clk);
    #($urandom_range(1, CLK_P - 1));
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  int           v0, e0, n0;
  logic [W-1:0] w_a, w_close;

  initial begin
    // Reset with sclk idle.
    repeat (5) @(posedge clk);
    #1;
    check("rst_parallel", 64'(parallel), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    settle();
    check("idle_locked", 64'(locked), 64'd0);

    // Three frames of one word: lock on the first start, two valids.
    half = 10 * $urandom_range(2, 4);
    align();
    v0 = n_valid; e0 = n_err;
    send_bit(1'b1, 1'b0);
    send_frame(32'hA5A5_3C3C, W, W/2);
    settle();
    check("locked_after_first_start", 64'(locked), 64'd1);
    send_frame(32'hA5A5_3C3C, W, W/2);
    send_frame(32'hA5A5_3C3C, W, W/2);
    settle();
    check("t1_valid_count", 64'(n_valid - v0), 64'd2);
    check("t1_err_count", 64'(n_err - e0), 64'd0);
    check("t1_parallel", 64'(parallel), 64'h0000_0000_A5A5_3C3C);

    // Back-to-back words: MSB/LSB placement and exact 32-sample spacing.
    half = 30;
    align();
    n0 = vcyc_q.size();
    w_close = $urandom;
    send_frame(32'h8000_0001, W, W/2);
    send_frame(32'h7FFF_FFFE, W, W/2);
    send_frame(w_close, W, W/2);
    settle();
    check("t2_valid_count", 64'(vcyc_q.size() - n0), 64'd3);
    if (vcyc_q.size() - n0 == 3)
      check("t2_spacing_clk", 64'(vcyc_q[n0+2] - vcyc_q[n0+1]), 64'(2 * W * half / CLK_P));
    check("t2_parallel", 64'(parallel), 64'h0000_0000_7FFF_FFFE);

    // Short frame (20 bits) then a correct frame.
    half = 10 * $urandom_range(2, 4);
    align();
    send_frame($urandom, 20, 10);
    settle();
    check("t3_prev_word", 64'(parallel), 64'(w_close));
    v0 = n_valid; e0 = n_err;
    send_frame(32'h1234_5678, W, W/2);
    settle();
    check("t3_short_err", 64'(n_err - e0), 64'd1);
    check("t3_no_valid", 64'(n_valid - v0), 64'd0);
    check("t3_parallel_held", 64'(parallel), 64'(w_close));
    check("t3_locked", 64'(locked), 64'd1);
    send_frame($urandom, W, W/2);
    settle();
    check("t3_parallel", 64'(parallel), 64'h0000_0000_1234_5678);

    // Overlong frame: ws high for 40 samples after a 16-sample low half.
    e0 = n_err;
    send_frame($urandom, 56, 16);
    settle();
    check("t4_overlong_err", 64'(n_err - e0), 64'd1);
    check("t4_unlocked", 64'(locked), 64'd0);
    v0 = n_valid;
    w_a = $urandom;
    send_frame(w_a, W, W/2);
    send_frame($urandom, W, W/2);
    settle();
    check("t4_one_valid", 64'(n_valid - v0), 64'd1);
    check("t4_parallel", 64'(parallel), 64'(w_a));
    check("t4_relocked", 64'(locked), 64'd1);

    // Reset mid-word: partial word discarded, relock needed.
    send_frame($urandom, 16, 16);
    sclk_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("t5_rst_parallel", 64'(parallel), 64'd0);
    check("t5_rst_valid", 64'(valid), 64'd0);
    check("t5_rst_frame_err", 64'(frame_err), 64'd0);
    check("t5_rst_locked", 64'(locked), 64'd0);
    v0 = n_valid;
    align();
    send_bit(1'b1, 1'b0);
    w_a = $urandom;
    send_frame(w_a, W, W/2);
    send_frame($urandom, W, W/2);
    settle();
    check("t5_one_valid", 64'(n_valid - v0), 64'd1);
    check("t5_parallel", 64'(parallel), 64'(w_a));

    // Minimum 4x ratio with random phase per frame.
    half = 2 * CLK_P;
    v0 = n_valid;
    for (int f = 0; f < 6; f++) begin
      align();
      send_frame(32'hDEAD_BEEF, W, W/2);
    end
    settle();
    check("t6_valid_count", 64'(n_valid - v0), 64'd6);
    check("t6_parallel", 64'(parallel), 64'h0000_0000_DEAD_BEEF);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
